// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-aware arbiter for the write port of an asynchronous FIFO.
// Optional stall counter output o_Stall_Cnt is enabled by defining FIFO_ARB_STALL_CNT_EN.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                     i_WR_clk,
  input  logic                     i_WR_rst_n,
  input  logic [NUM_REQ-1:0]       i_Req,
  input  logic [NUM_REQ*WIDTH-1:0] i_Data,
  input  logic                     i_Full,
  output logic [NUM_REQ-1:0]       o_Ack,
  output logic                     o_WR_En,
  output logic [WIDTH-1:0]         o_WR_Data,
  output logic [IDW-1:0]           o_Grant_ID,
  output logic                     o_Busy
`ifdef FIFO_ARB_STALL_CNT_EN
  , output logic [15:0]            o_Stall_Cnt
`endif
);

  localparam int CW   = $clog2(BURST_LEN + 1);
  localparam int IDW1 = IDW + 1;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t         state_reg, state_next;
  logic [IDW-1:0] owner_reg, owner_next;
  logic [IDW-1:0] last_reg, last_next;
  logic [CW-1:0]  cnt_reg, cnt_next;

  logic [WIDTH-1:0] data_word [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_data
      assign data_word[gi] = i_Data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Rotate requests so bit 0 is the requester just after last, then pick the lowest set bit.
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] req_shift;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDW:0]         shamt;
  logic [IDW:0]         sel_sum;
  logic [IDW-1:0]       sel_off;
  logic [IDW-1:0]       sel;
  logic                 sel_valid;

  assign req_dbl   = {i_Req, i_Req};
  assign shamt     = {1'b0, last_reg} + IDW1'(1);
  assign req_shift = req_dbl >> shamt;
  assign req_rot   = req_shift[NUM_REQ-1:0];
  assign sel_valid = |i_Req;

  always_comb begin
    sel_off = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) sel_off = IDW'(j);
    end
    sel_sum = shamt + {1'b0, sel_off};
    sel     = (sel_sum >= IDW1'(NUM_REQ)) ? IDW'(sel_sum - IDW1'(NUM_REQ)) : IDW'(sel_sum);
  end

  logic [CW-1:0] cnt_inc;
  assign cnt_inc = cnt_reg + CW'(1);

  always_ff @(posedge i_WR_clk) begin
    if (!i_WR_rst_n) begin
      state_reg <= ST_IDLE;
      owner_reg <= '0;
      last_reg  <= IDW'(NUM_REQ - 1);
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (sel_valid && !i_Full) begin
          if (BURST_LEN == 1) begin
            last_next = sel;
          end else begin
            owner_next = sel;
            cnt_next   = CW'(1);
            state_next = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        if (!i_Req[owner_reg]) begin
          // Owner withdrew: give up the grant, costing one dead cycle.
          state_next = ST_IDLE;
          last_next  = owner_reg;
        end else if (!i_Full) begin
          cnt_next = cnt_inc;
          if (cnt_inc == CW'(BURST_LEN)) begin
            state_next = ST_IDLE;
            last_next  = owner_reg;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  logic [IDW-1:0] grant;

  always_comb begin
    grant      = '0;
    o_WR_En    = 1'b0;
    o_WR_Data  = '0;
    o_Busy     = 1'b0;
    o_Ack      = '0;
    if (i_WR_rst_n) begin
      if (state_reg == ST_BURST) begin
        grant   = owner_reg;
        o_WR_En = i_Req[owner_reg] & ~i_Full;
        o_Busy  = 1'b1;
      end else begin
        grant   = sel;
        o_WR_En = sel_valid & ~i_Full;
      end
      o_WR_Data = data_word[grant];
      if (o_WR_En) o_Ack = NUM_REQ'(1) << grant;
    end
    o_Grant_ID = grant;
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  logic        want_wr;
  logic [15:0] stall_cnt_reg;

  assign want_wr = (state_reg == ST_BURST) ? i_Req[owner_reg] : sel_valid;

  always_ff @(posedge i_WR_clk) begin
    if (!i_WR_rst_n) begin
      stall_cnt_reg <= '0;
    end else if (want_wr && i_Full && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign o_Stall_Cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a grant/word-count model checked every cycle.
// Define FIFO_ARB_STALL_CNT_EN to also exercise the stall counter.
module tb_fifo_wr_arbiter;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int BL = 4;

  logic           clk;
  logic           i_WR_rst_n;
  logic [N-1:0]   i_Req;
  logic [N*W-1:0] i_Data;
  logic           i_Full;
  logic [N-1:0]   o_Ack;
  logic           o_WR_En;
  logic [W-1:0]   o_WR_Data;
  logic [1:0]     o_Grant_ID;
  logic           o_Busy;
`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0]    o_Stall_Cnt;
`endif

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .BURST_LEN(BL)) dut (
    .i_WR_clk   (clk),
    .i_WR_rst_n (i_WR_rst_n),
    .i_Req      (i_Req),
    .i_Data     (i_Data),
    .i_Full     (i_Full),
    .o_Ack      (o_Ack),
    .o_WR_En    (o_WR_En),
    .o_WR_Data  (o_WR_Data),
    .o_Grant_ID (o_Grant_ID),
    .o_Busy     (o_Busy)
`ifdef FIFO_ARB_STALL_CNT_EN
    , .o_Stall_Cnt(o_Stall_Cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int log_ids[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a grant is either open (owner, words used) or not; last is the rotation pointer.
  bit m_open = 0, n_open = 0;
  int m_owner = 0, n_owner = 0;
  int m_used = 0, n_used = 0;
  int m_last = N - 1, n_last = N - 1;
  int m_stall = 0, n_stall = 0;

  always @(posedge clk) begin
    m_open  <= n_open;
    m_owner <= n_owner;
    m_used  <= n_used;
    m_last  <= n_last;
    m_stall <= n_stall;
  end

  always @(negedge clk) begin
    bit e_wr, e_busy, found;
    int e_id;
    e_wr = 0; e_busy = 0; e_id = 0; found = 0;
    n_open = m_open; n_owner = m_owner; n_used = m_used; n_last = m_last; n_stall = m_stall;
    if (!i_WR_rst_n) begin
      n_open = 0; n_owner = 0; n_used = 0; n_last = N - 1; n_stall = 0;
    end else if (!m_open) begin
      for (int k = 1; k <= N; k++) begin
        if (!found && i_Req[(m_last + k) % N]) begin
          found = 1;
          e_id  = (m_last + k) % N;
        end
      end
      e_wr = found && !i_Full;
      if (found && i_Full && n_stall < 65535) n_stall = m_stall + 1;
      if (e_wr) begin
        if (BL == 1) n_last = e_id;
        else begin
          n_open = 1; n_owner = e_id; n_used = 1;
        end
      end
    end else begin
      e_busy = 1;
      e_id   = m_owner;
      e_wr   = i_Req[m_owner] && !i_Full;
      if (!i_Req[m_owner]) begin
        n_open = 0; n_last = m_owner;
      end else if (i_Full) begin
        if (n_stall < 65535) n_stall = m_stall + 1;
      end else begin
        n_used = m_used + 1;
        if (n_used == BL) begin
          n_open = 0; n_last = m_owner;
        end
      end
    end

    check("wr_en", int'(o_WR_En), int'(e_wr));
    check("ack", int'(o_Ack), e_wr ? (1 << e_id) : 0);
    check("busy", int'(o_Busy), int'(e_busy));
    if (e_wr || !i_WR_rst_n) begin
      check("grant_id", int'(o_Grant_ID), e_id);
      check("wr_data", int'(o_WR_Data), i_WR_rst_n ? int'(i_Data[e_id*W +: W]) : 0);
    end
`ifdef FIFO_ARB_STALL_CNT_EN
    check("stall_cnt", int'(o_Stall_Cnt), m_stall);
`endif
    if (o_WR_En) begin
      log_ids.push_back(int'(o_Grant_ID));
      $display("write id=%0d data=%02h full=%0d", o_Grant_ID, o_WR_Data, i_Full);
    end
  end

  task automatic set(input logic rst_n, input logic [N-1:0] req, input logic full);
    i_WR_rst_n = rst_n;
    i_Req      = req;
    i_Full     = full;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    i_Data = 32'h44332211;
    set(1'b0, 4'b1111, 1'b0);
    repeat (3) tick();
    check("reset_no_writes", log_ids.size(), 0);

    // Rotation: 20 cycles of full demand, first write right after release.
    log_ids.delete();
    i_Data = 32'hD3C2B1A0;
    set(1'b1, 4'b1111, 1'b0);
    #2;
    check("release_grant", int'(o_Grant_ID), 0);
    check("release_ack", int'(o_Ack), 1);
    repeat (20) tick();
    check("rot_len", log_ids.size(), 20);
    for (int i = 0; i < 20 && i < log_ids.size(); i++)
      check("rot_id", log_ids[i], (i / 4) % 4);

    // Priority wrap from last=0 with requesters 0 and 2.
    log_ids.delete();
    i_Data = 32'h5A6B7C8D;
    set(1'b1, 4'b0101, 1'b0);
    repeat (8) tick();
    check("wrap_len", log_ids.size(), 8);
    for (int i = 0; i < 8 && i < log_ids.size(); i++)
      check("wrap_id", log_ids[i], (i < 4) ? 2 : 0);

    // Early release by requester 1 after two words.
    log_ids.delete();
    set(1'b1, 4'b0010, 1'b0);
    repeat (2) tick();
    set(1'b1, 4'b0000, 1'b0);
    #2;
    check("dead_busy", int'(o_Busy), 1);
    check("dead_wr_en", int'(o_WR_En), 0);
    tick();
    check("early_len", log_ids.size(), 2);
    for (int i = 0; i < 2 && i < log_ids.size(); i++)
      check("early_id", log_ids[i], 1);

    // Full stall after requester 2's second word.
    log_ids.delete();
    i_Data = 32'hF0E1D2C3;
    set(1'b1, 4'b1111, 1'b0);
    #2;
    check("after_release_busy", int'(o_Busy), 0);
    check("after_release_grant", int'(o_Grant_ID), 2);
    tick();
    tick();
    set(1'b1, 4'b1111, 1'b1);
    repeat (3) begin
      #2;
      check("stall_grant", int'(o_Grant_ID), 2);
      check("stall_wr_en", int'(o_WR_En), 0);
      tick();
    end
    set(1'b1, 4'b1111, 1'b0);
    repeat (3) tick();
    check("stall_len", log_ids.size(), 5);
    for (int i = 0; i < 5 && i < log_ids.size(); i++)
      check("stall_id", log_ids[i], (i < 4) ? 2 : 3);

    // Reset in the middle of requester 3's burst returns priority to requester 0.
    set(1'b0, 4'b1111, 1'b0);
    tick();
    set(1'b1, 4'b1111, 1'b0);
    #2;
    check("midburst_reset_grant", int'(o_Grant_ID), 0);
    check("midburst_reset_busy", int'(o_Busy), 0);
    tick();

`ifdef FIFO_ARB_STALL_CNT_EN
    set(1'b0, 4'b0001, 1'b0);
    tick();
    log_ids.delete();
    set(1'b1, 4'b0001, 1'b1);
    repeat (5) tick();
    #2;
    check("stall_cnt_5", int'(o_Stall_Cnt), 5);
    check("stall_cnt_no_writes", log_ids.size(), 0);
    repeat (70000) tick();
    check("stall_cnt_sat", int'(o_Stall_Cnt), 65535);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin, burst-aware arbiter that shares the single write port of the asynchronous FIFO among NUM_REQ requesters in the write clock domain. It selects one requester, muxes its data onto the FIFO write port and lets it write up to BURST_LEN words before rotating. Writes are throttled by the FIFO's o_Full flag. It sits between the write-side producers and the FIFO_Async write port (i_WR_Data, i_WR_En, o_Full).

## Interface
- WIDTH, 8, data word width; matches the FIFO WIDTH
- NUM_REQ, 4, number of requesters (2..16); IDW = clog2(NUM_REQ) is derived
- BURST_LEN, 4, maximum words per grant (≥1)
- i_WR_clk  in  1  write-domain clock, rising edge
- i_WR_rst_n  in  1  synchronous active-low reset
- i_Req  in  NUM_REQ  per-requester write request; level, held while data is pending
- i_Data  in  NUM_REQ*WIDTH  requester k word at bits [k*WIDTH +: WIDTH]
- i_Full  in  1  FIFO full flag, from FIFO_Async o_Full
- o_Ack  out  NUM_REQ  one-hot; bit k high means requester k's word is written at this edge
- o_WR_En  out  1  to FIFO i_WR_En
- o_WR_Data  out  WIDTH  to FIFO i_WR_Data
- o_Grant_ID  out  IDW  index of the requester whose word is on o_WR_Data
- o_Busy  out  1  high while in BURST state

## Operation
- The FSM has two states, IDLE and BURST. Its registers are state, owner (IDW bits), last (IDW bits, round-robin pointer) and cnt (clog2(BURST_LEN+1) bits).
- Selection: sel is the first k with i_Req[k]=1, searching from last+1 upward and wrapping modulo NUM_REQ.
- IDLE, with any i_Req set and i_Full=0:
  - accept sel's word (o_WR_En=1, o_Ack[sel]=1, o_WR_Data=i_Data[sel], o_Grant_ID=sel).
  - If BURST_LEN=1: last<=sel and stay in IDLE.
  - Otherwise: owner<=sel, cnt<=1 and go to BURST.
- IDLE, with i_Full=1 or no request: no write and no state change.
- BURST: o_Grant_ID=owner and o_WR_En = i_Req[owner] & ~i_Full.
  - On accept: cnt<=cnt+1. If cnt+1==BURST_LEN, go to IDLE with last<=owner.
  - If i_Req[owner]=0: no write this cycle, go to IDLE with last<=owner (one dead cycle).
  - If i_Full=1 with the request held: stall. owner and cnt are held and the grant is not lost.
- Only the owner can write in BURST; other requests wait.
- Requesters must hold i_Data stable while i_Req=1 and o_Ack is low. Each high o_Ack consumes exactly one word.
- Reset (including mid-burst): state=IDLE, owner=0, cnt=0, last=NUM_REQ-1 so requester 0 wins first.
  - While i_WR_rst_n=0, o_WR_En, o_Ack and o_Busy are forced to 0, o_WR_Data to 0 and o_Grant_ID to 0.
- A word is never written while i_Full=1.

## Timing
- Accept path is combinational, zero latency: i_Req/i_Full go to o_WR_En/o_Ack in the same cycle, and the FIFO captures at that edge.
- Throughput is one word per cycle while requests are present and not full, including across the BURST→IDLE→new grant boundary when the burst ends by count. IDLE grants immediately.
- Losing a grant by dropping i_Req costs one idle cycle.
- i_Full is sampled in the same cycle as o_WR_En. The FIFO's registered full flag already covers its pointer latency, so no extra margin is required.
- State, owner, cnt and last update only on the rising edge of i_WR_clk.

## Configuration
- FIFO_ARB_STALL_CNT_EN defined:
  - adds output o_Stall_Cnt, 16 bits;
  - it increments each cycle in which a write is wanted but i_Full=1 (in IDLE: any i_Req set; in BURST: i_Req[owner] set);
  - it saturates at 16'hFFFF and resets to 0.
- Not defined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- Reset: hold i_WR_rst_n=0 for 3 cycles with i_Req=4'b1111. Required: o_WR_En=0 and o_Ack=0 throughout; in the first cycle after release, o_Grant_ID=0 and o_Ack=4'b0001.
- Rotation: i_Req=4'b1111 held, i_Full=0, BURST_LEN=4, 20 cycles. Required: o_Grant_ID sequence 0×4, 1×4, 2×4, 3×4, 0×4, with o_WR_En=1 every cycle.
- Early release: only requester 1 requests and drops i_Req after 2 acks. Required: 2 writes, then one cycle with o_WR_En=0, o_Busy falls, and the next grant starts search at 2.
- Full stall: i_Full=1 for 3 cycles after the 2nd word of requester 2's burst. Required: o_WR_En=0 for 3 cycles, owner stays 2, and exactly 2 more words follow before rotation.
- Priority wrap: last=0, i_Req=4'b0101. Required: requester 2 is granted before requester 0.
- With FIFO_ARB_STALL_CNT_EN: i_Full=1 and i_Req=4'b0001 for 5 cycles. Required: o_Stall_Cnt=5 and no writes; forcing 70000 stall cycles leaves it at 65535.
